segre_mem_arbiter: RTL and testbench
====================================

# segre_mem_arbiter

Sits directly downstream of the instruction and data caches and owns the single main-memory port. Latches line-fill requests from both caches and line writebacks from the data cache into one-deep pending buffers. Grants one request at a time: round-robin between caches, writeback-before-fill inside the data-cache group. Drives the memory handshake and returns filled lines with a one-cycle received pulse that feeds the caches' `rcvd_mem_request_i`.

## Interface
- `WORD_SIZE`, package value (32): address width.
- `CACHE_LINE_SIZE_BYTES`, package value (16): line width in bytes. `OFF = $clog2(CACHE_LINE_SIZE_BYTES)`.
- `clk_i` in 1: the block's single clock.
- `rsn_i` in 1: asynchronous, active-low reset.
- `ic_rd_i` in 1: instruction-cache line-fill request.
- `ic_addr_i` in WORD_SIZE: fill address.
- `ic_rcvd_o` out 1: fill complete, one-cycle pulse.
- `ic_line_o` out CACHE_LINE_SIZE_BYTES×8: fill data, valid while `ic_rcvd_o` is high.
- `dc_rd_i`, `dc_addr_i`, `dc_rcvd_o`, `dc_line_o`: data-cache fill port, same meanings as the instruction-cache fill port.
- `dc_wb_i` in 1: data-cache writeback request.
- `dc_wb_addr_i` in WORD_SIZE: writeback address.
- `dc_wb_line_i` in CACHE_LINE_SIZE_BYTES×8: writeback data.
- `mem_req_o` out 1: memory request, held until accepted.
- `mem_we_o` out 1: 1 = write, 0 = read.
- `mem_addr_o` out WORD_SIZE: line-aligned address, low OFF bits are 0.
- `mem_wdata_o` out CACHE_LINE_SIZE_BYTES×8: write data.
- `mem_rdata_i` in CACHE_LINE_SIZE_BYTES×8: read data, valid with `mem_ready_i`.
- `mem_ready_i` in 1: memory completes the current request when sampled high.

## Operation
- **Pending buffers.** There are three: IC (fill), DC (fill), WB (writeback).
  - A buffer captures on a clock edge when its request input is high and the buffer is empty. IC and DC capture the address; WB captures the address and the line.
  - A request seen while the buffer is full is ignored.
  - A buffer clears at the edge that ends its completion cycle.
  - Requests are level-sampled. A request still high in the cycle after `*_rcvd_o` is treated as a new request. A one-cycle pulse is sufficient to post a request.
- **FSM states.**
  - IDLE: if any buffer is valid, select a winner, load the `mem_*` registers, go to MEM.
  - MEM: `mem_req_o` = 1 with outputs stable. When `mem_ready_i` is sampled high: a read captures `mem_rdata_i` and goes to RESP; a write clears WB and goes to IDLE.
  - RESP: the granted port's `*_rcvd_o` = 1 and `*_line_o` = captured line for exactly this cycle, then IDLE.
- **Arbitration.**
  - WB always beats DC. A writeback therefore always reaches memory before the refill that replaces it.
  - Round-robin between the IC group and the DC group (WB or DC). `last_grant` points at the group granted last; the other group wins on contention. Reset value: DC group, so IC wins first.
  - A sole pending requester wins regardless of the pointer.
- **Writeback completion.** A writeback produces no `dc_rcvd_o` pulse. `dc_rcvd_o` is reserved for fills, so the cache's fill-wait state never sees a false completion.
- **Address alignment.** `mem_addr_o = {addr[WORD_SIZE-1:OFF], OFF'b0}`. Requester low bits are discarded.
- **Reset.** Asynchronous reset mid-transaction clears all buffers, returns the FSM to IDLE, drops `mem_req_o` immediately, and discards any in-flight response.

## Timing
- Reset values: all outputs 0, lines 0, FSM IDLE, `last_grant` = DC.
- All outputs are registered; there is no combinational input-to-output path.
- Minimum fill latency, request first high in cycle 0:
  - buffer valid in cycle 1;
  - `mem_req_o` high in cycle 2;
  - with `mem_ready_i` high in cycle 2, `*_rcvd_o` is high in cycle 3.
- Each extra cycle without `mem_ready_i` adds one cycle.
- Back-to-back: the next grant is evaluated in the IDLE cycle after RESP. There is one dead cycle between memory transactions (`mem_req_o` low for ≥1 cycle).
- `mem_ready_i` is ignored outside MEM.
- A request arriving in the cycle its own buffer clears is not captured. Requesters re-post it.

## Structure
- Shared package: `mem_arb_state_e` {IDLE, MEM, RESP} and `mem_grp_e` {GRP_IC, GRP_DC}. `CACHE_LINE_SIZE_BYTES` and `WORD_SIZE` already live there.
- Sub-module `segre_mem_req_buffer`: one-deep valid/address/line register with capture and clear inputs, parameterised on data width. Instantiated three times; the fill instances carry address only.

## Test plan
- IC fill `addr=0x0000_1234`, memory ready immediately → `mem_addr_o=0x0000_1230`, `mem_we_o=0`, `ic_rcvd_o` high in cycle 3 with `ic_line_o=mem_rdata_i`.
- DC fill and IC fill posted in the same cycle after reset → IC served first, then DC. The two `mem_req_o` windows are separated by ≥1 idle cycle.
- WB (`0x100`, line `0xAA..AA`) and DC fill (`0x200`) posted in the same cycle:
  - write to `0x100` with the line `0xAA..AA` precedes the read of `0x200`;
  - no `dc_rcvd_o` pulse for the write;
  - exactly one pulse for the read.
- Memory withholds `mem_ready_i` for 7 cycles → `mem_req_o`, `mem_addr_o` and `mem_we_o` stay stable for 7 cycles; `rcvd` fires one cycle after ready.
- `rsn_i` low while in MEM → `mem_req_o` drops immediately. After release, `mem_ready_i`=1 produces no `rcvd` pulse.
- IC holds `ic_rd_i` high continuously → a fill every 4 cycles with ready-immediate memory; DC requests are interleaved round-robin.

Source files
------------

// File: rtl/segre_mem_arbiter_pkg.sv
// Shared types and sizes for the cache-to-memory arbiter.
//   WORD_SIZE             : address width
//   CACHE_LINE_SIZE_BYTES : line width in bytes; LINE_W is the same in bits
//   OFF                   : number of line-offset address bits
//   mem_arb_state_e       : arbiter FSM states
//   mem_grp_e             : requester groups for round-robin
package segre_mem_arbiter_pkg;
    localparam int WORD_SIZE             = 32;
    localparam int CACHE_LINE_SIZE_BYTES = 16;
    localparam int LINE_W                = CACHE_LINE_SIZE_BYTES * 8;
    localparam int OFF                   = $clog2(CACHE_LINE_SIZE_BYTES);

    typedef enum logic [1:0] {IDLE, MEM, RESP} mem_arb_state_e;
    typedef enum logic       {GRP_IC, GRP_DC}   mem_grp_e;

    // Drop the byte-in-line offset so memory always sees a line address.
    function automatic logic [WORD_SIZE-1:0] line_align(input logic [WORD_SIZE-1:0] addr);
        return {addr[WORD_SIZE-1:OFF], {OFF{1'b0}}};
    endfunction
endpackage

// File: rtl/segre_mem_arbiter_if.sv
// Main-memory port bundle.
//   req   : request, held until ready
//   we    : 1 = write, 0 = read
//   addr  : line-aligned address
//   wdata : write line
//   rdata : read line, valid with ready
//   ready : memory completes the request when sampled high
// master = arbiter side, slave = memory side.
interface segre_mem_arbiter_if
    import segre_mem_arbiter_pkg::*;
;
    logic                 req;
    logic                 we;
    logic [WORD_SIZE-1:0] addr;
    logic [LINE_W-1:0]    wdata;
    logic [LINE_W-1:0]    rdata;
    logic                 ready;

    modport master (output req, we, addr, wdata, input rdata, ready);
    modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/segre_mem_req_buffer.sv
// One-deep pending-request buffer.
//   clk_i, rsn_i : clock, async active-low reset
//   req          : level request; captured only while the buffer is empty
//   clear        : empties the buffer at this edge
//   din          : payload to capture with the request
//   valid        : buffer holds a request
//   dout         : captured payload
module segre_mem_req_buffer #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rsn_i,
    input  logic         req,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic         valid,
    output logic [W-1:0] dout
);
    // A request seen while full (including the clearing cycle) is dropped.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (req && !valid) begin
            valid <= 1'b1;
            dout  <= din;
        end
    end
endmodule

// File: rtl/segre_mem_arbiter.sv
// Arbiter owning the single main-memory port for the instruction and data caches.
//   clk_i, rsn_i               : clock, async active-low reset
//   ic_rd_i / ic_addr_i        : I-cache fill request and address
//   ic_rcvd_o / ic_line_o      : I-cache fill done pulse and line
//   dc_rd_i / dc_addr_i        : D-cache fill request and address
//   dc_rcvd_o / dc_line_o      : D-cache fill done pulse and line
//   dc_wb_i / dc_wb_addr_i /
//   dc_wb_line_i               : D-cache writeback request, address and line
//   mem                        : memory port (master side)
//
// state | meaning
// IDLE  | pick a winner among valid buffers and load the memory registers
// MEM   | memory request held stable until ready
// RESP  | one-cycle rcvd pulse to the granted cache, then its buffer clears
module segre_mem_arbiter
    import segre_mem_arbiter_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rsn_i,
    input  logic                       ic_rd_i,
    input  logic [WORD_SIZE-1:0]       ic_addr_i,
    output logic                       ic_rcvd_o,
    output logic [LINE_W-1:0]          ic_line_o,
    input  logic                       dc_rd_i,
    input  logic [WORD_SIZE-1:0]       dc_addr_i,
    output logic                       dc_rcvd_o,
    output logic [LINE_W-1:0]          dc_line_o,
    input  logic                       dc_wb_i,
    input  logic [WORD_SIZE-1:0]       dc_wb_addr_i,
    input  logic [LINE_W-1:0]          dc_wb_line_i,
    segre_mem_arbiter_if.master        mem
);
    logic                        ic_v, dc_v, wb_v;
    logic                        ic_clr, dc_clr, wb_clr;
    logic [WORD_SIZE-1:0]        ic_addr, dc_addr, wb_addr;
    logic [LINE_W-1:0]           wb_line;
    logic                        ic_wins;

    mem_arb_state_e              state_q, state_d;
    mem_grp_e                    grant_q, grant_d, last_q, last_d;
    logic                        req_q, req_d, we_q, we_d;
    logic [WORD_SIZE-1:0]        addr_q, addr_d;
    logic [LINE_W-1:0]           wdata_q, wdata_d, line_q, line_d;
    logic                        ic_rcvd_q, ic_rcvd_d, dc_rcvd_q, dc_rcvd_d;

    segre_mem_req_buffer #(.W(WORD_SIZE)) u_ic_buf (
        .clk_i(clk_i), .rsn_i(rsn_i), .req(ic_rd_i), .clear(ic_clr),
        .din(ic_addr_i), .valid(ic_v), .dout(ic_addr)
    );

    segre_mem_req_buffer #(.W(WORD_SIZE)) u_dc_buf (
        .clk_i(clk_i), .rsn_i(rsn_i), .req(dc_rd_i), .clear(dc_clr),
        .din(dc_addr_i), .valid(dc_v), .dout(dc_addr)
    );

    segre_mem_req_buffer #(.W(WORD_SIZE + LINE_W)) u_wb_buf (
        .clk_i(clk_i), .rsn_i(rsn_i), .req(dc_wb_i), .clear(wb_clr),
        .din({dc_wb_addr_i, dc_wb_line_i}), .valid(wb_v), .dout({wb_addr, wb_line})
    );

    // IC wins when it is the only group pending or the DC group was served last.
    assign ic_wins = ic_v && (!(dc_v || wb_v) || (last_q == GRP_DC));

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q   <= IDLE;
            grant_q   <= GRP_IC;
            last_q    <= GRP_DC;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            line_q    <= '0;
            ic_rcvd_q <= 1'b0;
            dc_rcvd_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            line_q    <= line_d;
            ic_rcvd_q <= ic_rcvd_d;
            dc_rcvd_q <= dc_rcvd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        line_d    = line_q;
        ic_rcvd_d = 1'b0;
        dc_rcvd_d = 1'b0;
        ic_clr    = 1'b0;
        dc_clr    = 1'b0;
        wb_clr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ic_v || dc_v || wb_v) begin
                    state_d = MEM;
                    req_d   = 1'b1;
                    if (ic_wins) begin
                        grant_d = GRP_IC;
                        we_d    = 1'b0;
                        addr_d  = line_align(ic_addr);
                        wdata_d = '0;
                    end else if (wb_v) begin
                        // Writeback first so memory is updated before its refill.
                        grant_d = GRP_DC;
                        we_d    = 1'b1;
                        addr_d  = line_align(wb_addr);
                        wdata_d = wb_line;
                    end else begin
                        grant_d = GRP_DC;
                        we_d    = 1'b0;
                        addr_d  = line_align(dc_addr);
                        wdata_d = '0;
                    end
                    last_d = grant_d;
                end
            end
            MEM: begin
                if (mem.ready) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        // Writebacks complete silently; dc_rcvd_o is for fills only.
                        wb_clr  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        line_d    = mem.rdata;
                        ic_rcvd_d = (grant_q == GRP_IC);
                        dc_rcvd_d = (grant_q == GRP_DC);
                        state_d   = RESP;
                    end
                end
            end
            RESP: begin
                ic_clr  = (grant_q == GRP_IC);
                dc_clr  = (grant_q == GRP_DC);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem.req   = req_q;
    assign mem.we    = we_q;
    assign mem.addr  = addr_q;
    assign mem.wdata = wdata_q;
    assign ic_rcvd_o = ic_rcvd_q;
    assign dc_rcvd_o = dc_rcvd_q;
    assign ic_line_o = line_q;
    assign dc_line_o = line_q;
endmodule

// File: tb/tb_segre_mem_arbiter.sv
module tb_segre_mem_arbiter;
    import segre_mem_arbiter_pkg::*;

    logic                 clk_i;
    logic                 rsn_i;
    logic                 ic_rd_i;
    logic [WORD_SIZE-1:0] ic_addr_i;
    logic                 ic_rcvd_o;
    logic [LINE_W-1:0]    ic_line_o;
    logic                 dc_rd_i;
    logic [WORD_SIZE-1:0] dc_addr_i;
    logic                 dc_rcvd_o;
    logic [LINE_W-1:0]    dc_line_o;
    logic                 dc_wb_i;
    logic [WORD_SIZE-1:0] dc_wb_addr_i;
    logic [LINE_W-1:0]    dc_wb_line_i;

    int total = 0;
    int bad   = 0;
    int dc_pulses;
    logic [19:0] ic_seen, dc_seen, req_seen;

    segre_mem_arbiter_if mem_bus ();

    segre_mem_arbiter dut (
        .clk_i        (clk_i),
        .rsn_i        (rsn_i),
        .ic_rd_i      (ic_rd_i),
        .ic_addr_i    (ic_addr_i),
        .ic_rcvd_o    (ic_rcvd_o),
        .ic_line_o    (ic_line_o),
        .dc_rd_i      (dc_rd_i),
        .dc_addr_i    (dc_addr_i),
        .dc_rcvd_o    (dc_rcvd_o),
        .dc_line_o    (dc_line_o),
        .dc_wb_i      (dc_wb_i),
        .dc_wb_addr_i (dc_wb_addr_i),
        .dc_wb_line_i (dc_wb_line_i),
        .mem          (mem_bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
        if (dc_rcvd_o === 1'b1) dc_pulses++;
    endtask

    localparam logic [LINE_W-1:0] R1 = {4{32'hDEAD_0001}};
    localparam logic [LINE_W-1:0] R2 = {4{32'h1234_5678}};
    localparam logic [LINE_W-1:0] R3 = {4{32'hCAFE_0003}};
    localparam logic [LINE_W-1:0] R4 = {4{32'h0BAD_F00D}};
    localparam logic [LINE_W-1:0] R5 = {4{32'h5555_6666}};
    localparam logic [LINE_W-1:0] WB_LINE = {16{8'hAA}};
    localparam logic [19:0] EXP_IC  = (20'd1 << 3) | (20'd1 << 9) | (20'd1 << 13) | (20'd1 << 17);
    localparam logic [19:0] EXP_DC  = (20'd1 << 6);
    localparam logic [19:0] EXP_REQ = (20'd1 << 2) | (20'd1 << 5) | (20'd1 << 8) | (20'd1 << 12) | (20'd1 << 16);

    initial begin
        rsn_i = 1'b0;
        ic_rd_i = 1'b0; ic_addr_i = '0;
        dc_rd_i = 1'b0; dc_addr_i = '0;
        dc_wb_i = 1'b0; dc_wb_addr_i = '0; dc_wb_line_i = '0;
        mem_bus.ready = 1'b0; mem_bus.rdata = '0;
        dc_pulses = 0;

        // Reset values
        tick(); tick(); tick();
        chk("rst_req",     mem_bus.req, 0);
        chk("rst_we",      mem_bus.we, 0);
        chk("rst_addr",    mem_bus.addr, 0);
        chk("rst_wdata",   mem_bus.wdata, 0);
        chk("rst_ic_rcvd", ic_rcvd_o, 0);
        chk("rst_dc_rcvd", dc_rcvd_o, 0);
        chk("rst_ic_line", ic_line_o, 0);
        rsn_i = 1'b1;
        tick();

        // Single IC fill, ready immediately
        ic_rd_i = 1'b1; ic_addr_i = 32'h0000_1234;           // cycle 0
        chk("t1_c0_req", mem_bus.req, 0);
        tick(); ic_rd_i = 1'b0;                               // cycle 1
        chk("t1_c1_req", mem_bus.req, 0);
        tick();                                               // cycle 2
        chk("t1_c2_req",  mem_bus.req, 1);
        chk("t1_c2_addr", mem_bus.addr, 32'h0000_1230);
        chk("t1_c2_we",   mem_bus.we, 0);
        mem_bus.ready = 1'b1; mem_bus.rdata = R1;
        tick(); mem_bus.ready = 1'b0;                         // cycle 3
        chk("t1_c3_ic_rcvd", ic_rcvd_o, 1);
        chk("t1_c3_ic_line", ic_line_o, R1);
        chk("t1_c3_dc_rcvd", dc_rcvd_o, 0);
        chk("t1_c3_req",     mem_bus.req, 0);
        tick();                                               // cycle 4
        chk("t1_c4_ic_rcvd", ic_rcvd_o, 0);
        chk("t1_c4_req",     mem_bus.req, 0);

        // IC and DC posted together after reset: IC first, dead cycle, then DC
        rsn_i = 1'b0; tick(); rsn_i = 1'b1; tick();
        ic_rd_i = 1'b1; ic_addr_i = 32'h0000_4000;
        dc_rd_i = 1'b1; dc_addr_i = 32'h0000_5008;           // cycle 0
        tick(); ic_rd_i = 1'b0; dc_rd_i = 1'b0;              // cycle 1
        tick();                                               // cycle 2
        chk("t2_c2_req",  mem_bus.req, 1);
        chk("t2_c2_addr", mem_bus.addr, 32'h0000_4000);
        mem_bus.ready = 1'b1; mem_bus.rdata = R2;
        tick(); mem_bus.ready = 1'b0;                         // cycle 3
        chk("t2_c3_ic_rcvd", ic_rcvd_o, 1);
        chk("t2_c3_ic_line", ic_line_o, R2);
        chk("t2_c3_req",     mem_bus.req, 0);
        tick();                                               // cycle 4
        chk("t2_c4_dead_req", mem_bus.req, 0);
        tick();                                               // cycle 5
        chk("t2_c5_req",  mem_bus.req, 1);
        chk("t2_c5_addr", mem_bus.addr, 32'h0000_5000);
        chk("t2_c5_we",   mem_bus.we, 0);
        mem_bus.ready = 1'b1; mem_bus.rdata = R3;
        tick(); mem_bus.ready = 1'b0;                         // cycle 6
        chk("t2_c6_dc_rcvd", dc_rcvd_o, 1);
        chk("t2_c6_dc_line", dc_line_o, R3);
        chk("t2_c6_ic_rcvd", ic_rcvd_o, 0);
        tick();                                               // cycle 7
        chk("t2_c7_dc_rcvd", dc_rcvd_o, 0);

        // WB and DC fill together: write first, single fill pulse
        dc_pulses = 0;
        dc_wb_i = 1'b1; dc_wb_addr_i = 32'h0000_0100; dc_wb_line_i = WB_LINE;
        dc_rd_i = 1'b1; dc_addr_i = 32'h0000_0200;           // cycle 0
        tick(); dc_wb_i = 1'b0; dc_rd_i = 1'b0;              // cycle 1
        tick();                                               // cycle 2
        chk("t3_c2_req",   mem_bus.req, 1);
        chk("t3_c2_we",    mem_bus.we, 1);
        chk("t3_c2_addr",  mem_bus.addr, 32'h0000_0100);
        chk("t3_c2_wdata", mem_bus.wdata, WB_LINE);
        mem_bus.ready = 1'b1; mem_bus.rdata = R5;
        tick(); mem_bus.ready = 1'b0;                         // cycle 3
        chk("t3_c3_dc_rcvd", dc_rcvd_o, 0);
        chk("t3_c3_req",     mem_bus.req, 0);
        tick();                                               // cycle 4
        chk("t3_c4_req",  mem_bus.req, 1);
        chk("t3_c4_we",   mem_bus.we, 0);
        chk("t3_c4_addr", mem_bus.addr, 32'h0000_0200);
        mem_bus.ready = 1'b1; mem_bus.rdata = R4;
        tick(); mem_bus.ready = 1'b0;                         // cycle 5
        chk("t3_c5_dc_rcvd", dc_rcvd_o, 1);
        chk("t3_c5_dc_line", dc_line_o, R4);
        tick(); tick();
        chk("t3_dc_pulses", dc_pulses, 1);

        // Memory stalls for 7 cycles
        ic_rd_i = 1'b1; ic_addr_i = 32'h3000_00FF;           // cycle 0
        tick(); ic_rd_i = 1'b0;                               // cycle 1
        tick();                                               // cycle 2
        mem_bus.rdata = R1;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("t4_stall%0d_req", i),  mem_bus.req, 1);
            chk($sformatf("t4_stall%0d_addr", i), mem_bus.addr, 32'h3000_00F0);
            chk($sformatf("t4_stall%0d_we", i),   mem_bus.we, 0);
            chk($sformatf("t4_stall%0d_rcvd", i), ic_rcvd_o, 0);
            tick();
        end
        chk("t4_req_before_ready", mem_bus.req, 1);
        mem_bus.ready = 1'b1;
        tick(); mem_bus.ready = 1'b0;
        chk("t4_ic_rcvd", ic_rcvd_o, 1);
        chk("t4_ic_line", ic_line_o, R1);
        tick();

        // Reset asserted while in MEM
        ic_rd_i = 1'b1; ic_addr_i = 32'h0000_6000;
        tick(); ic_rd_i = 1'b0;
        tick();
        chk("t5_req_in_mem", mem_bus.req, 1);
        #1 rsn_i = 1'b0;
        #1 chk("t5_req_async_drop", mem_bus.req, 0);
        mem_bus.ready = 1'b1; mem_bus.rdata = R2;
        tick(); rsn_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t5_post%0d_ic_rcvd", i), ic_rcvd_o, 0);
            chk($sformatf("t5_post%0d_req", i),     mem_bus.req, 0);
        end
        mem_bus.ready = 1'b0;
        tick();

        // IC held high continuously, one DC fill interleaved; memory always ready
        mem_bus.ready = 1'b1; mem_bus.rdata = R3;
        ic_rd_i = 1'b1; ic_addr_i = 32'h0000_7000;
        dc_rd_i = 1'b1; dc_addr_i = 32'h0000_8000;
        for (int c = 0; c < 20; c++) begin
            ic_seen[c]  = ic_rcvd_o;
            dc_seen[c]  = dc_rcvd_o;
            req_seen[c] = mem_bus.req;
            tick();
            dc_rd_i = 1'b0;
        end
        chk("t6_ic_rcvd_pattern", ic_seen, EXP_IC);
        chk("t6_dc_rcvd_pattern", dc_seen, EXP_DC);
        chk("t6_req_pattern",     req_seen, EXP_REQ);
        ic_rd_i = 1'b0;
        mem_bus.ready = 1'b0;
        tick(); tick(); tick(); tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
